eps_integrator: RTL and testbench

Per-output error integrator sitting directly downstream of the cost-evaluation stage. It consumes the five stochastic error bitstreams `eps` and their sign lines `SIGN_L3`, and integrates each into a saturating signed count over one training window. At each window boundary it hands the five binary error values to the weight-update controller through a valid/ready handshake.

---
 rtl/snn_cost_pkg.sv | 13 +
 rtl/eps_lane.sv | 44 ++++
 rtl/eps_integrator.sv | 101 ++++++++++
 tb/tb_eps_integrator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_cost_pkg.sv
// rtl/snn_cost_pkg.sv - shared defaults and output-side state type for the cost/error path
package snn_cost_pkg;

  localparam int DEF_N_OUT      = 5;
  localparam int DEF_ACC_W      = 10;
  localparam int DEF_WINDOW_MAX = 255;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/eps_lane.sv
// rtl/eps_lane.sv - one saturating up/down error accumulator with reload and abs/sign view
module eps_lane #(
  parameter int ACC_W = 10
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             eps,
  input  logic             sign,
  input  logic             reload,
  output logic [ACC_W-1:0] mag,
  output logic             neg
);

  // Symmetric limits: the most negative code is never produced, so |acc| fits ACC_W-1 bits.
  localparam logic [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;

  always_comb begin
    acc_nxt = acc;
    if (reload) begin
      if (eps) acc_nxt = sign ? {ACC_W{1'b1}} : ACC_ONE;
      else     acc_nxt = '0;
    end else if (eps) begin
      if (sign) begin
        if (acc != ACC_MIN) acc_nxt = acc - ACC_ONE;
      end else begin
        if (acc != ACC_MAX) acc_nxt = acc + ACC_ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (INIT) acc <= '0;
    else      acc <= acc_nxt;
  end

  assign neg = acc[ACC_W-1];
  assign mag = neg ? (~acc + ACC_ONE) : acc;

endmodule

// File: rtl/eps_integrator.sv
// rtl/eps_integrator.sv - windowed per-lane error integration with valid/ready result hand-off
module eps_integrator
  import snn_cost_pkg::*;
#(
  parameter int N_OUT      = DEF_N_OUT,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int WINDOW_MAX = DEF_WINDOW_MAX
) (
  input  logic                   CLK,
  input  logic                   INIT,
  input  logic                   CLK_TRAINING_flag,
  input  logic [N_OUT-1:0]       eps,
  input  logic [N_OUT-1:0]       SIGN_L3,
  output logic [N_OUT*ACC_W-1:0] err_mag,
  output logic [N_OUT-1:0]       err_sign,
  output logic                   err_valid,
  input  logic                   err_ready,
  output logic                   overrun
);

  localparam int SMP_W = (WINDOW_MAX < 2) ? 1 : $clog2(WINDOW_MAX + 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WINDOW_MAX);
  localparam logic [SMP_W-1:0] SMP_ONE  = SMP_W'(1);

  out_state_t state;
  out_state_t state_nxt;

  logic                   flag_d;
  logic [SMP_W-1:0]       smp;
  logic                   flag_edge;
  logic                   close;
  logic                   handshake;
  logic                   take;
  logic                   ovr_set;
  logic [N_OUT*ACC_W-1:0] lane_mag;
  logic [N_OUT-1:0]       lane_neg;

  assign err_valid = (state == FULL);
  assign handshake = err_valid & err_ready;
  assign flag_edge = CLK_TRAINING_flag & ~flag_d;
  assign close     = flag_edge | (smp == SMP_LAST);

  // The sample seen in the closing cycle seeds the next window via reload.
  for (genvar i = 0; i < N_OUT; i++) begin : g_lane
    eps_lane #(
      .ACC_W (ACC_W)
    ) u_lane (
      .CLK    (CLK),
      .INIT   (INIT),
      .eps    (eps[i]),
      .sign   (SIGN_L3[i]),
      .reload (close),
      .mag    (lane_mag[i*ACC_W +: ACC_W]),
      .neg    (lane_neg[i])
    );
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      EMPTY: begin
        if (close) begin
          state_nxt = FULL;
          take      = 1'b1;
        end
      end
      FULL: begin
        if (close) begin
          state_nxt = FULL;
          if (handshake) take    = 1'b1;
          else           ovr_set = 1'b1;
        end else if (handshake) begin
          state_nxt = EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state    <= EMPTY;
      flag_d   <= 1'b0;
      smp      <= '0;
      err_mag  <= '0;
      err_sign <= '0;
      overrun  <= 1'b0;
    end else begin
      state  <= state_nxt;
      flag_d <= CLK_TRAINING_flag;
      smp    <= close ? SMP_ONE : smp + SMP_ONE;
      if (take) begin
        err_mag  <= lane_mag;
        err_sign <= lane_neg;
      end
      if (ovr_set) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eps_integrator.sv
// tb/tb_eps_integrator.sv - directed self-checking bench for eps_integrator
module tb_eps_integrator;

  localparam int N_OUT = 5;
  localparam int ACC_W = 10;

  logic                   CLK = 1'b0;
  logic                   INIT;
  logic                   flag;
  logic [N_OUT-1:0]       eps;
  logic [N_OUT-1:0]       sgn;
  logic                   err_ready;

  logic [N_OUT*ACC_W-1:0] err_mag;
  logic [N_OUT-1:0]       err_sign;
  logic                   err_valid;
  logic                   overrun;

  logic [N_OUT*ACC_W-1:0] s_err_mag;
  logic [N_OUT-1:0]       s_err_sign;
  logic                   s_err_valid;
  logic                   s_overrun;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  eps_integrator #(
    .N_OUT(N_OUT), .ACC_W(ACC_W), .WINDOW_MAX(255)
  ) dut (
    .CLK(CLK), .INIT(INIT), .CLK_TRAINING_flag(flag), .eps(eps), .SIGN_L3(sgn),
    .err_mag(err_mag), .err_sign(err_sign), .err_valid(err_valid),
    .err_ready(err_ready), .overrun(overrun)
  );

  eps_integrator #(
    .N_OUT(N_OUT), .ACC_W(ACC_W), .WINDOW_MAX(1023)
  ) dut_sat (
    .CLK(CLK), .INIT(INIT), .CLK_TRAINING_flag(flag), .eps(eps), .SIGN_L3(sgn),
    .err_mag(s_err_mag), .err_sign(s_err_sign), .err_valid(s_err_valid),
    .err_ready(err_ready), .overrun(s_overrun)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    INIT = 1'b1;
    flag = 1'b0;
    eps = '0;
    sgn = '0;
    err_ready = 1'b0;
    tick(1);
    INIT = 1'b0;
  endtask

  initial begin
    INIT = 1'b1;
    flag = 1'b0;
    err_ready = 1'b0;
    eps = 5'($urandom_range(0, 31));
    sgn = 5'($urandom_range(0, 31));
    tick(1);
    eps = 5'($urandom_range(0, 31));
    sgn = 5'($urandom_range(0, 31));
    tick(1);
    chk("rst_valid", err_valid, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_mag", err_mag, '0);
    chk("rst_sign", err_sign, '0);

    // basic count: lane0 +20, lane1 -7
    INIT = 1'b0;
    eps = '0;
    sgn = '0;
    tick(1);
    for (int k = 0; k < 20; k++) begin
      eps = (k < 7) ? 5'b00011 : 5'b00001;
      sgn = 5'b00010;
      tick(1);
    end
    eps = '0;
    sgn = '0;
    tick(3);
    chk("basic_pre_valid", err_valid, 1'b0);
    flag = 1'b1;
    tick(1);
    chk("basic_valid", err_valid, 1'b1);
    chk("basic_mag", err_mag, 64'd20 | (64'd7 << 10));
    chk("basic_sign", err_sign, 5'b00010);

    // result stays stable while unaccepted
    eps = 5'b00001;
    tick(5);
    chk("hold_mag", err_mag, 64'd20 | (64'd7 << 10));
    chk("hold_valid", err_valid, 1'b1);
    eps = '0;
    err_ready = 1'b1;
    tick(1);
    err_ready = 1'b0;
    chk("accept_valid", err_valid, 1'b0);
    chk("accept_overrun", overrun, 1'b0);

    // edge-cycle sample belongs to the new window
    do_reset();
    eps = 5'b01000;
    tick(3);
    flag = 1'b1;
    tick(1);
    chk("edge_mag", err_mag, 64'd3 << 30);
    eps = '0;
    flag = 1'b0;
    err_ready = 1'b1;
    tick(1);
    err_ready = 1'b0;
    chk("edge_accept", err_valid, 1'b0);
    flag = 1'b1;
    tick(1);
    chk("edge_new_valid", err_valid, 1'b1);
    chk("edge_new_mag", err_mag, 64'd1 << 30);

    // overrun: second close with unaccepted result
    flag = 1'b0;
    eps = 5'b10000;
    sgn = 5'b10000;
    tick(9);
    flag = 1'b1;
    tick(1);
    chk("ovr_set", overrun, 1'b1);
    chk("ovr_valid", err_valid, 1'b1);
    chk("ovr_mag_kept", err_mag, 64'd1 << 30);
    chk("ovr_sign_kept", err_sign, 5'b00000);
    eps = '0;
    sgn = '0;
    err_ready = 1'b1;
    tick(1);
    err_ready = 1'b0;
    chk("ovr_accept_valid", err_valid, 1'b0);
    chk("ovr_sticky", overrun, 1'b1);

    // simultaneous close and handshake
    do_reset();
    eps = 5'b00001;
    tick(4);
    eps = '0;
    flag = 1'b1;
    tick(1);
    chk("sim_first_mag", err_mag, 64'd4);
    flag = 1'b0;
    eps = 5'b00010;
    sgn = 5'b00010;
    tick(6);
    eps = '0;
    sgn = '0;
    flag = 1'b1;
    err_ready = 1'b1;
    tick(1);
    err_ready = 1'b0;
    chk("sim_valid", err_valid, 1'b1);
    chk("sim_mag", err_mag, 64'd6 << 10);
    chk("sim_sign", err_sign, 5'b00010);
    chk("sim_overrun", overrun, 1'b0);

    // mid-window INIT discards the partial window and overrides an edge
    do_reset();
    eps = 5'b00001;
    tick(5);
    INIT = 1'b1;
    flag = 1'b1;
    tick(1);
    chk("init_override", err_valid, 1'b0);
    INIT = 1'b0;
    flag = 1'b0;
    eps = '0;
    tick(1);
    flag = 1'b1;
    tick(1);
    chk("init_disc_valid", err_valid, 1'b1);
    chk("init_disc_mag", err_mag, '0);

    // forced close at WINDOW_MAX, next window counts from 1
    do_reset();
    eps = 5'b00100;
    tick(255);
    chk("force_pre_valid", err_valid, 1'b0);
    tick(1);
    chk("force_valid", err_valid, 1'b1);
    chk("force_mag", err_mag, 64'd255 << 20);
    err_ready = 1'b1;
    tick(1);
    err_ready = 1'b0;
    tick(253);
    chk("force2_pre_valid", err_valid, 1'b0);
    tick(1);
    chk("force2_valid", err_valid, 1'b1);
    chk("force2_mag", err_mag, 64'd255 << 20);

    // saturation on the long-window instance, both directions
    do_reset();
    eps = 5'b00011;
    sgn = 5'b00010;
    tick(600);
    chk("sat_pre_valid", s_err_valid, 1'b0);
    eps = '0;
    sgn = '0;
    flag = 1'b1;
    tick(1);
    chk("sat_valid", s_err_valid, 1'b1);
    chk("sat_mag", s_err_mag, 64'd511 | (64'd511 << 10));
    chk("sat_sign", s_err_sign, 5'b00010);
    chk("sat_overrun", s_overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
